// File: rtl/wb_cmd_master_pkg.sv
// Shared types for the Wishbone command master.
// FSM state encoding, default error word, counter sizing helper.
package wb_cmd_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [31:0] ERR_DATA_DEF = 32'hFFFF_FFFF;
  localparam logic [7:0]  ERR_CNT_MAX  = 8'hFF;

  // Counter only ever holds 0..limit-1; it expires on the last value.
  function automatic int ctr_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/wb_cmd_master_timeout_ctr.sv
// Bus-cycle timeout counter: clr zeroes, en counts up.
// Ports: clk, rst, clr, en in; expired out (on the LIMIT-th cycle).
module wb_timeout_ctr
  import wb_cmd_master_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = ctr_width(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High during the LIMIT-th bus cycle, so cyc stays up LIMIT cycles.
  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/wb_cmd_master.sv
// Single-outstanding command -> Wishbone classic master with timeout.
// Ports: cmd_* request, rsp_* response, wbm_* bus, err_count.
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic [7:0]  err_count
);

  state_e      state_q, state_d;
  logic        rdy_q, rdy_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        rv_q, rv_d;
  logic [31:0] rdat_q, rdat_d;
  logic        rerr_q, rerr_d;
  logic [7:0]  ecnt_q, ecnt_d;
  logic        t_clr, t_en, t_exp;

  wb_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .clr    (t_clr),
    .en     (t_en),
    .expired(t_exp)
  );

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rv_d    = rv_q;
    rdat_d  = rdat_q;
    rerr_d  = rerr_q;
    ecnt_d  = ecnt_q;
    t_clr   = 1'b0;
    t_en    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        t_clr = 1'b1;
        if (cmd_valid) begin
          state_d = ST_BUS;
          cyc_d   = 1'b1;
          we_d    = cmd_we;
          sel_d   = cmd_sel;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
        end
      end
      ST_BUS: begin
        // Ack is checked first so it wins over a same-cycle timeout.
        if (wbm_ack_i || t_exp) begin
          state_d = ST_RESP;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = '0;
          adr_d   = '0;
          dat_d   = '0;
          rv_d    = 1'b1;
          if (wbm_ack_i) begin
            rdat_d = we_q ? 32'h0 : wbm_dat_i;
            rerr_d = 1'b0;
          end else begin
            rdat_d = ERR_DATA;
            rerr_d = 1'b1;
            if (ecnt_q != ERR_CNT_MAX) begin
              ecnt_d = ecnt_q + 8'd1;
            end
          end
        end else begin
          t_en = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          rv_d    = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    rdy_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      rdy_q   <= 1'b1;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      rv_q    <= 1'b0;
      rdat_q  <= '0;
      rerr_q  <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rv_q    <= rv_d;
      rdat_q  <= rdat_d;
      rerr_q  <= rerr_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign cmd_ready = rdy_q;
  assign rsp_valid = rv_q;
  assign rsp_dat   = rdat_q;
  assign rsp_err   = rerr_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign err_count = ecnt_q;

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum cycles a bus transfer waits for wb ack before it is aborted (valid range 1..65535).
REQ-002 SHALL have parameter ERR_DATA, default 32'hFFFF_FFFF: rsp_dat value returned on timeout.
REQ-003 SHALL have one clock and a synchronous, active-high reset: wb_clk_i in 1, rising-edge clock; wb_rst_i in 1, synchronous active-high reset.
REQ-004 SHALL have ports: cmd_valid in 1, command present; cmd_ready out 1, command accepted; cmd_we in 1, 1=write 0=read; cmd_adr in 32, address; cmd_dat in 32, write data; cmd_sel in 4, byte selects.
REQ-005 SHALL have ports: rsp_valid out 1, response present; rsp_ready in 1, response consumed; rsp_dat out 32, read data; rsp_err out 1, timeout flag.
REQ-006 SHALL have ports: wbm_cyc_o out 1; wbm_stb_o out 1; wbm_we_o out 1; wbm_sel_o out 4; wbm_adr_o out 32; wbm_dat_o out 32; wbm_dat_i in 32; wbm_ack_i in 1 (Wishbone classic master, drives the housekeeping slave port).
REQ-007 SHALL have port err_count out 8: saturating count of timed-out transfers.

Function
REQ-008 SHALL implement states IDLE, BUS, RESP; cmd_ready=1 only in IDLE.
REQ-009 IDLE: on cmd_valid&&cmd_ready, SHALL register adr/dat/sel/we and enter BUS; wbm_cyc_o/wbm_stb_o rise the following cycle (one-cycle command-to-bus latency).
REQ-010 BUS: cyc, stb, we, sel, adr, dat SHALL be held stable every cycle until ack or timeout.
REQ-011 BUS: on a cycle with wbm_ack_i=1, SHALL capture wbm_dat_i (reads) or 32'h0 (writes) into rsp_dat, set rsp_err=0, deassert cyc/stb at the next edge, enter RESP.
REQ-012 Timer SHALL reset to 0 on BUS entry, increment each BUS cycle without ack; when it reaches TIMEOUT_CYCLES, SHALL deassert cyc/stb, set rsp_dat=ERR_DATA, rsp_err=1, increment err_count (saturate at 255), enter RESP.
REQ-013 Ack and timeout in the same cycle: ack SHALL win (normal completion, no err_count increment).
REQ-014 RESP: rsp_valid=1 with rsp_dat/rsp_err stable until rsp_ready=1; on that cycle SHALL return to IDLE; a new command is acceptable no earlier than the next cycle.
REQ-015 wbm_ack_i in IDLE or RESP SHALL be ignored.
REQ-016 cmd_* inputs SHALL be ignored outside IDLE; commands are never queued (single outstanding transfer).
REQ-017 wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o SHALL be 0 when cyc is low.

Reset
REQ-018 On wb_rst_i=1 at a clock edge SHALL enter IDLE; wbm_cyc_o=0, wbm_stb_o=0, wbm_we_o=0, wbm_sel_o=0, wbm_adr_o=0, wbm_dat_o=0, rsp_valid=0, rsp_dat=0, rsp_err=0, err_count=0, timer=0, and cmd_ready=1 after reset.
REQ-019 Reset during BUS or RESP SHALL drop cyc/stb/rsp_valid at that edge; the in-flight transfer and its response are discarded.

Structure
REQ-020 State encoding (IDLE/BUS/RESP) and the default ERR_DATA constant SHALL live in the shared wb package.
REQ-021 Timeout counter SHALL be a sub-module wb_timeout_ctr (clear, enable, expired output), width derived from TIMEOUT_CYCLES.
REQ-022 All outputs SHALL be registered; no combinational path from wbm_ack_i to cmd_ready or to rsp_valid.

Verification
REQ-023 Write adr 32'h2620_001B, dat 1, sel 4'hF; slave acks after 2 cycles -> exactly one cyc/stb assertion with stable fields, rsp_valid with rsp_err=0, rsp_dat=0.
REQ-024 Read of same address, slave returns 32'h0000_0001 -> rsp_dat=32'h0000_0001, rsp_err=0; back-to-back write/read round trip matches.
REQ-025 TIMEOUT_CYCLES=16, slave never acks -> cyc drops after 16 BUS cycles, rsp_err=1, rsp_dat=32'hFFFF_FFFF, err_count=1; 300 timeouts -> err_count=255.
REQ-026 rsp_ready held low 5 cycles -> rsp_valid and rsp_dat stable, cmd_ready=0, cmd_valid pulses ignored throughout.
REQ-027 Ack arrives exactly on timeout cycle -> normal completion, err_count unchanged; stray ack in IDLE -> no response.
REQ-028 wb_rst_i asserted for 1 cycle mid-BUS -> cyc/stb low at that edge, no rsp_valid, next command completes normally.
